// File: rtl/uart_alu_bridge.sv
// Sequences UART bytes into ALU operands A, B and opcode, then hands the ALU
// result back to the transmitter with a one-cycle start pulse.
module uart_alu_bridge #(
    parameter int length = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [length-1:0] rx_data,
    input  logic              rx_done,
    input  logic [length-1:0] alu_result,
    input  logic              tx_done,
    output logic [length-1:0] busA,
    output logic [length-1:0] busB,
    output logic [5:0]        op,
    output logic [length-1:0] tx_data,
    output logic              tx_start,
    output logic              busy
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        COMPUTE = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no branch leaves state_next unassigned and no latch is inferred.
        state_next = state;
        case (state)
            GET_A:   if (rx_done) state_next = GET_B;
            GET_B:   if (rx_done) state_next = GET_OP;
            GET_OP:  if (rx_done) state_next = COMPUTE;
            COMPUTE: state_next = WAIT_TX;
            WAIT_TX: if (tx_done) state_next = GET_A;
            default: state_next = GET_A;
        endcase
    end

    // Operand, opcode and result registers; each loads only in its own state,
    // so bytes arriving while busy are dropped without disturbing them.
    always_ff @(posedge clk) begin
        if (reset) begin
            busA     <= '0;
            busB     <= '0;
            op       <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            tx_start <= 1'b0;
            case (state)
                GET_A:   if (rx_done) busA <= rx_data;
                GET_B:   if (rx_done) busB <= rx_data;
                GET_OP:  if (rx_done) op <= rx_data[5:0];
                COMPUTE: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == COMPUTE) || (state == WAIT_TX);

endmodule

// File: doc/uart_alu_bridge.md
UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

Interface
REQ-001 Parameter: length, default 8, data width of operands, result and UART byte.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 rx_data  in  length  byte from UART receiver, valid while rx_done=1.
REQ-005 rx_done  in  1  one-cycle pulse: receiver has a new byte.
REQ-006 alu_result  in  length  combinational result from ALU (fed by busA/busB/op).
REQ-007 tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
REQ-008 busA  out  length  registered operand A to ALU.
REQ-009 busB  out  length  registered operand B to ALU.
REQ-010 op  out  6  registered ALU opcode.
REQ-011 tx_data  out  length  registered result byte to transmitter.
REQ-012 tx_start  out  1  registered one-cycle pulse: start transmission of tx_data.
REQ-013 busy  out  1  high while a result is being computed or transmitted.

Function
REQ-014 FSM states: GET_A, GET_B, GET_OP, COMPUTE, WAIT_TX; exactly one state active.
REQ-015 GET_A: rx_done=1 -> busA<=rx_data, next GET_B; else hold.
REQ-016 GET_B: rx_done=1 -> busB<=rx_data, next GET_OP; else hold.
REQ-017 GET_OP: rx_done=1 -> op<=rx_data[5:0] (upper bits discarded), next COMPUTE; else hold.
REQ-018 COMPUTE: lasts exactly one cycle; at its closing edge tx_data<=alu_result, tx_start<=1, next WAIT_TX.
REQ-019 WAIT_TX: tx_start<=0 at first edge (pulse width exactly one cycle); tx_done=1 -> next GET_A; else hold.
REQ-020 Latency: tx_start=1 in the second cycle after the cycle in which the opcode byte's rx_done=1.
REQ-021 tx_data SHALL remain stable from tx_start assertion until the return to GET_A.
REQ-022 busA, busB, op SHALL hold their last values until overwritten by a new byte in the matching state.
REQ-023 rx_done in COMPUTE or WAIT_TX SHALL be ignored (byte dropped, no register change).
REQ-024 tx_done outside WAIT_TX SHALL be ignored.
REQ-025 rx_done and tx_done both high in WAIT_TX -> transition to GET_A, byte dropped (not captured as A).
REQ-026 busy=1 exactly when state is COMPUTE or WAIT_TX; busy is a decode of the state register.
REQ-027 No arithmetic performed in this block; alu_result passed through unmodified, width length.

Reset
REQ-028 reset=1 at a rising edge -> state GET_A, busA=0, busB=0, op=0, tx_data=0, tx_start=0, busy=0, regardless of current state.
REQ-029 reset overrides rx_done and tx_done in the same cycle; an in-flight sequence is abandoned and no tx_start is emitted for it.
REQ-030 After reset is released, the first rx_done byte SHALL be captured as busA.

Verification (bench instantiates the team's alu, length=8)
REQ-031 Bytes 0x05, 0x03, 0x20 -> busA=0x05, busB=0x03, op=0x20; tx_start one-cycle pulse 2 cycles after third rx_done; tx_data=0x08; busy=1 until tx_done.
REQ-032 Bytes 0x03, 0x05, 0x22 -> tx_data=0xFE; then bytes 0x80, 0x02, 0x03 after tx_done -> tx_data=0xE0 (arithmetic shift).
REQ-033 Opcode byte 0xFF -> op=0x3F (undefined) -> tx_data=0x00, tx_start still pulsed.
REQ-034 rx_done pulses with 0x77 during WAIT_TX, then tx_done -> busA unchanged; next byte 0x11 captured as busA=0x11.
REQ-035 reset asserted one cycle after second byte (state GET_OP) -> all outputs 0, state GET_A, no tx_start; next sequence 0x01, 0x01, 0x20 -> tx_data=0x02.
REQ-036 tx_done pulsed in GET_A/GET_B -> no state change; tx_done and rx_done simultaneous in WAIT_TX -> GET_A, byte not captured.
